// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants for the RISC-V core
//
// Holds the fetch FSM state encoding and the default word width / bubble
// encoding used by the fetch stage and the stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // free to issue a request
    S_WAIT = 2'd1,  // request outstanding, response will be kept
    S_KILL = 2'd2   // request outstanding, response will be discarded
  } fetch_state_t;

  localparam int          DEFAULT_WORD_BITWIDTH = 32;
  localparam logic [31:0] DEFAULT_NOP_INSTR     = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline stage register with hold/flush/load controls
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   hold                keep current contents
//   flush               force a bubble (wins over hold)
//   load                capture load_pc/load_instr as a real instruction
//   load_pc, load_instr incoming PC and instruction
//   valid, pc, instr    registered stage contents; instr is NOP on a bubble
module if_id_reg
  import pipe_pkg::*;
#(
  parameter int                     WIDTH = DEFAULT_WORD_BITWIDTH,
  parameter logic [WIDTH-1:0]       NOP   = WIDTH'(DEFAULT_NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pc,
  input  logic [WIDTH-1:0] load_instr,
  output logic             valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr
);

  // A bubble keeps the old pc so downstream debug still sees the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP;
    end else if (!hold) begin
      if (load) begin
        valid <= 1'b1;
        pc    <= load_pc;
        instr <= load_instr;
      end else begin
        valid <= 1'b0;
        instr <= NOP;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   stall                          hold PC and IF/ID (load-use hazard)
//   pc_src, branch_target          redirect fetch and bubble IF/ID
//   imem_req_valid/addr/ready      instruction memory request handshake
//   imem_rsp_valid/data            in-order response, one per accepted request
//   id_valid, id_pc, id_instr      IF/ID contents presented to decode
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int                         WORD_BITWIDTH = DEFAULT_WORD_BITWIDTH,
  parameter logic [WORD_BITWIDTH-1:0]   RESET_PC      = '0,
  parameter logic [WORD_BITWIDTH-1:0]   NOP_INSTR     = WORD_BITWIDTH'(DEFAULT_NOP_INSTR)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     pc_src,
  input  logic [WORD_BITWIDTH-1:0] branch_target,
  output logic                     imem_req_valid,
  output logic [WORD_BITWIDTH-1:0] imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [WORD_BITWIDTH-1:0] imem_rsp_data,
  output logic                     id_valid,
  output logic [WORD_BITWIDTH-1:0] id_pc,
  output logic [WORD_BITWIDTH-1:0] id_instr
);

  fetch_state_t             state;
  logic [WORD_BITWIDTH-1:0] pc;
  logic [WORD_BITWIDTH-1:0] req_pc;     // address of the outstanding request
  logic                     buf_valid;  // response captured while stalled
  logic [WORD_BITWIDTH-1:0] buf_pc;
  logic [WORD_BITWIDTH-1:0] buf_instr;

  logic                     req_fire;
  logic                     live_rsp;
  logic [WORD_BITWIDTH-1:0] load_pc;
  logic [WORD_BITWIDTH-1:0] load_instr;

  // Gating with rst_n keeps the bus quiet while the core is held in reset.
  assign imem_req_valid = rst_n && (state == S_REQ) && !buf_valid && !pc_src;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign live_rsp       = (state == S_WAIT) && imem_rsp_valid;

  // The buffer always predates any live response, so it is drained first.
  assign load_pc    = buf_valid ? buf_pc    : req_pc;
  assign load_instr = buf_valid ? buf_instr : imem_rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      req_pc    <= '0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= '0;
    end else if (pc_src) begin
      pc        <= branch_target;
      buf_valid <= 1'b0;
      // A response arriving with the redirect is simply dropped.
      if (state == S_WAIT) begin
        state <= imem_rsp_valid ? S_REQ : S_KILL;
      end else if (state == S_KILL && imem_rsp_valid) begin
        state <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          // A request already on the bus cannot be retracted by a stall,
          // so an accepted request always advances pc.
          if (req_fire) begin
            pc     <= pc + WORD_BITWIDTH'(4);
            req_pc <= pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state <= S_REQ;
            if (stall) begin
              buf_valid <= 1'b1;
              buf_pc    <= req_pc;
              buf_instr <= imem_rsp_data;
            end
          end
        end
        S_KILL: begin
          if (imem_rsp_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
      if (!stall && buf_valid) buf_valid <= 1'b0;
    end
  end

  if_id_reg #(
    .WIDTH (WORD_BITWIDTH),
    .NOP   (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (stall),
    .flush      (pc_src),
    .load       (buf_valid || live_rsp),
    .load_pc    (load_pc),
    .load_instr (load_instr),
    .valid      (id_valid),
    .pc         (id_pc),
    .instr      (id_instr)
  );

  // A response with nothing outstanding means the memory lost sync with us.
  rsp_without_req_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(state == S_REQ && imem_rsp_valid));

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] SIG = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .imem_req_valid (req_valid),
    .imem_req_addr  (req_addr),
    .imem_req_ready (req_ready),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_err;
  int          n_checks;
  // memory model: one outstanding request, response after next_lat cycles
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          next_lat;
  // program-order reference: next address to request / to deliver
  logic [31:0] exp_req;
  logic [31:0] exp_del;
  logic        prev_valid;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic        obs_rv;
  logic [31:0] obs_ra;
  int          deliveries;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_ref();
    exp_req    = 32'h0;
    exp_del    = 32'h0;
    prev_valid = 1'b0;
    prev_pc    = 32'h0;
    prev_instr = NOP;
  endtask

  // One clock cycle; entered and left #1 after a rising edge.
  task automatic cycle();
    logic        fired, hs, s_stall, s_src;
    logic [31:0] s_tgt;
    fired     = rst_n && mem_busy && (mem_cnt == 0);
    rsp_valid = fired;
    rsp_data  = fired ? (mem_addr ^ SIG) : 32'hDEAD_BEEF;
    #4;
    obs_rv = req_valid;
    obs_ra = req_addr;
    hs     = req_valid && req_ready;
    if (rst_n) begin
      if (pc_src) check("req_blocked_by_redirect", 32'(obs_rv), 32'd0);
      if (hs) begin
        check("req_addr_order", obs_ra, exp_req);
        exp_req = exp_req + 32'd4;
      end
    end
    s_stall = stall;
    s_src   = pc_src;
    s_tgt   = branch_target;
    @(posedge clk);
    #1;
    if (fired) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (hs) begin
      mem_busy = 1'b1;
      mem_addr = obs_ra;
      mem_cnt  = next_lat - 1;
    end
    if (rst_n) begin
      if (s_src) begin
        check("flush_valid", 32'(id_valid), 32'd0);
        check("flush_instr", id_instr, NOP);
        check("flush_pc", id_pc, prev_pc);
        exp_req = s_tgt;
        exp_del = s_tgt;
      end else if (s_stall) begin
        check("stall_hold_valid", 32'(id_valid), 32'(prev_valid));
        check("stall_hold_pc", id_pc, prev_pc);
        check("stall_hold_instr", id_instr, prev_instr);
      end else if (id_valid) begin
        check("deliver_pc", id_pc, exp_del);
        check("deliver_instr", id_instr, exp_del ^ SIG);
        exp_del = exp_del + 32'd4;
        deliveries++;
      end else begin
        check("bubble_instr", id_instr, NOP);
        check("bubble_pc", id_pc, prev_pc);
      end
    end
    prev_valid = id_valid;
    prev_pc    = id_pc;
    prev_instr = id_instr;
  endtask

  initial begin
    n_err = 0; n_checks = 0; deliveries = 0;
    rst_n = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0;
    mem_busy = 1'b0; mem_addr = 32'h0; mem_cnt = 0; next_lat = 1;
    obs_rv = 1'b0; obs_ra = 32'h0;
    reset_ref();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_valid", 32'(req_valid), 32'd0);
    check("reset_id_valid", 32'(id_valid), 32'd0);
    check("reset_id_instr", id_instr, NOP);
    check("reset_id_pc", id_pc, 32'h0);
    rst_n = 1'b1;

    // straight-line fetch, ready=1, k=1
    cycle();  // 1
    check("c1_req_valid", 32'(obs_rv), 32'd1);
    check("c1_req_addr", obs_ra, 32'h0);
    check("c1_id_valid", 32'(id_valid), 32'd0);
    cycle();  // 2
    check("c3_first_valid", 32'(id_valid), 32'd1);
    check("c3_id_pc", id_pc, 32'h0);
    cycle();  // 3
    check("c4_bubble", 32'(id_valid), 32'd0);
    cycle();  // 4
    check("c5_id_pc", id_pc, 32'h4);
    cycle();  // 5
    cycle();  // 6
    check("c7_id_pc", id_pc, 32'h8);
    check("c7_id_instr", id_instr, 32'hA5A5_0008);

    // stall while the response for 12 arrives
    cycle();  // 7
    check("stall_pre_req", obs_ra, 32'hC);
    stall = 1'b1;
    cycle();  // 8
    check("stall_buf_valid", 32'(dut.buf_valid), 32'd1);
    check("stall_id_pc", id_pc, 32'h8);
    cycle();  // 9
    check("stall_no_req_a", 32'(obs_rv), 32'd0);
    cycle();  // 10
    check("stall_no_req_b", 32'(obs_rv), 32'd0);
    stall = 1'b0;
    cycle();  // 11
    check("unstall_no_req", 32'(obs_rv), 32'd0);
    check("unstall_id_valid", 32'(id_valid), 32'd1);
    check("unstall_id_pc", id_pc, 32'hC);
    next_lat = 3;
    cycle();  // 12
    check("unstall_next_req", 32'(obs_rv), 32'd1);
    check("unstall_next_addr", obs_ra, 32'h10);
    next_lat = 1;

    // redirect while waiting; the response comes back two cycles later
    pc_src = 1'b1; branch_target = 32'h100;
    cycle();  // 13
    pc_src = 1'b0;
    check("kill_id_valid", 32'(id_valid), 32'd0);
    cycle();  // 14
    check("kill_no_req_a", 32'(obs_rv), 32'd0);
    cycle();  // 15
    check("kill_no_req_b", 32'(obs_rv), 32'd0);
    check("kill_dropped", 32'(id_valid), 32'd0);
    cycle();  // 16
    check("kill_target_req", 32'(obs_rv), 32'd1);
    check("kill_target_addr", obs_ra, 32'h100);
    cycle();  // 17
    check("target_id_pc", id_pc, 32'h100);
    check("target_id_instr", id_instr, 32'hA5A5_0100);

    // redirect and stall together with a live response
    cycle();  // 18
    stall = 1'b1; pc_src = 1'b1; branch_target = 32'h200;
    cycle();  // 19
    stall = 1'b0; pc_src = 1'b0;
    check("both_id_valid", 32'(id_valid), 32'd0);
    check("both_id_instr", id_instr, NOP);
    cycle();  // 20
    check("both_target_addr", obs_ra, 32'h200);
    cycle();  // 21

    // pc wrap at the top of the address space
    pc_src = 1'b1; branch_target = 32'hFFFF_FFFC;
    cycle();  // 22
    pc_src = 1'b0;
    cycle();  // 23
    check("wrap_top_addr", obs_ra, 32'hFFFF_FFFC);
    cycle();  // 24
    check("wrap_top_id_pc", id_pc, 32'hFFFF_FFFC);
    next_lat = 3;
    cycle();  // 25
    check("wrap_next_valid", 32'(obs_rv), 32'd1);
    check("wrap_next_addr", obs_ra, 32'h0);
    next_lat = 1;

    // asynchronous reset with a request outstanding
    cycle();  // 26
    #2 rst_n = 1'b0;
    #1;
    check("areset_req_valid", 32'(req_valid), 32'd0);
    check("areset_id_valid", 32'(id_valid), 32'd0);
    check("areset_id_instr", id_instr, NOP);
    check("areset_id_pc", id_pc, 32'h0);
    @(posedge clk);
    #1;
    mem_busy = 1'b0;
    rsp_valid = 1'b0;
    reset_ref();
    rst_n = 1'b1;
    cycle();
    check("areset_first_valid", 32'(obs_rv), 32'd1);
    check("areset_first_addr", obs_ra, 32'h0);

    // randomized traffic against the program-order reference
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom_range(0, 99) < 25);
      pc_src        = ($urandom_range(0, 99) < 4);
      branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      req_ready     = ($urandom_range(0, 99) < 70);
      next_lat      = $urandom_range(1, 3);
      cycle();
    end
    stall = 1'b0; pc_src = 1'b0;
    check("random_progress", 32'(deliveries > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
